// File: rtl/bus_pkg.sv
// Shared bus definitions: source count, vector widths, source indices and arbiter state.
// The bus-select encoder and the bus mux use these definitions too.
package bus_pkg;

  localparam int N_SRC      = 24;
  localparam int GRANT_W    = 32;
  localparam int MAX_TENURE = 4;
  localparam int PTR_W      = 5;
  localparam int CNT_W      = 4;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHIGH  = 18;
  localparam int SRC_ZLOW   = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_SRC-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_SRC; i++)
      if (oh[i]) idx = idx | PTR_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/bus_source_arbiter_rr_pick.sv
// Round-robin pick: first eligible request at or above ptr, wrapping to 0.
// The candidate vector is doubled with the lower copy masked below ptr, then the lowest set bit is isolated.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N  = N_SRC,
  parameter int PW = PTR_W
) (
  input  logic [N-1:0]  lreq,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  pick,
  output logic          found
);

  logic [N-1:0]   cand;
  logic [N-1:0]   thermo;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  always_comb begin
    cand   = lreq & ~excl;
    thermo = {N{1'b1}} << ptr;
    masked = {cand, cand & thermo};
    first  = masked & (~masked + (2*N)'(1));
    pick   = first[N-1:0] | first[2*N-1:N];
    found  = |cand;
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin bus-source arbiter with bounded tenure; drives a registered one-hot grant
// straight into the bus-select encoder.
module bus_source_arbiter
  import bus_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic [GRANT_W-1:0] req,
  output logic [GRANT_W-1:0] grant,
  output logic               grant_valid,
  output logic               illegal_req
);

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [N_SRC-1:0] lreq;
  logic [N_SRC-1:0] holder;
  logic [N_SRC-1:0] excl;
  logic [N_SRC-1:0] pick;
  logic             found;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] ptr_next;
  logic             holder_req;

  assign lreq       = req[N_SRC-1:0];
  assign holder     = grant[N_SRC-1:0];
  assign holder_req = |(lreq & holder);
  // Excluding the holder is harmless on release since its request is already low.
  assign excl       = (state == GRANT) ? holder : '0;
  assign pick_idx   = onehot_to_idx(pick);
  assign ptr_next   = (pick_idx == PTR_W'(N_SRC-1)) ? '0 : pick_idx + PTR_W'(1);

  rr_pick #(.N(N_SRC), .PW(PTR_W)) u_pick (
    .lreq  (lreq),
    .ptr   (ptr),
    .excl  (excl),
    .pick  (pick),
    .found (found)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      illegal_req <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      illegal_req <= |req[GRANT_W-1:N_SRC];
      case (state)
        IDLE: begin
          if (found) begin
            state       <= GRANT;
            grant       <= {{(GRANT_W-N_SRC){1'b0}}, pick};
            grant_valid <= 1'b1;
            cnt         <= CNT_W'(1);
            ptr         <= ptr_next;
          end
        end
        GRANT: begin
          if (!holder_req || (cnt == CNT_W'(MAX_TENURE) && found)) begin
            if (found) begin
              grant       <= {{(GRANT_W-N_SRC){1'b0}}, pick};
              grant_valid <= 1'b1;
              cnt         <= CNT_W'(1);
              ptr         <= ptr_next;
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
            end
          end else if (cnt != CNT_W'(MAX_TENURE)) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed and randomized checks of bus_source_arbiter against a behavioural round-robin model.
module tb_bus_source_arbiter;

  localparam int NS  = 24;
  localparam int MT  = 4;

  logic        clock;
  logic        clear;
  logic [31:0] req;
  logic [31:0] grant;
  logic        grant_valid;
  logic        illegal_req;

  int total = 0;
  int bad   = 0;

  // reference model: holder index (-1 = idle), pointer, tenure count
  int          m_holder;
  int          m_ptr;
  int          m_cnt;
  logic        m_ill;
  logic [31:0] m_grant;

  bus_source_arbiter dut (
    .clock       (clock),
    .clear       (clear),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .illegal_req (illegal_req)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int model_pick(input logic [31:0] r, input int from, input int skip);
    for (int k = 0; k < NS; k++) begin
      int i;
      i = (from + k) % NS;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [31:0] r, input logic c);
    int p;
    if (c) begin
      m_holder = -1; m_ptr = 0; m_cnt = 0; m_ill = 1'b0;
    end else begin
      m_ill = (r[31:NS] != 0);
      p = -1;
      if (m_holder < 0) p = model_pick(r, m_ptr, -1);
      else if (!r[m_holder]) begin
        p = model_pick(r, m_ptr, m_holder);
        if (p < 0) m_holder = -1;
      end else if (m_cnt == MT) p = model_pick(r, m_ptr, m_holder);
      else m_cnt = m_cnt + 1;
      if (p >= 0) begin
        m_holder = p; m_cnt = 1; m_ptr = (p + 1) % NS;
      end
    end
    m_grant = (m_holder < 0) ? 32'h0 : (32'h1 << m_holder);
  endtask

  task automatic step(input logic [31:0] r, input logic c, input string tag);
    @(negedge clock);
    req = r; clear = c;
    model_edge(r, c);
    @(posedge clock);
    #1;
    total++;
    assert (grant === m_grant) else begin
      bad++; $error("FAIL %s grant got=%h want=%h", tag, grant, m_grant);
    end
    total++;
    assert (grant_valid === (m_grant != 0)) else begin
      bad++; $error("FAIL %s grant_valid got=%b want=%b", tag, grant_valid, (m_grant != 0));
    end
    total++;
    assert (illegal_req === m_ill) else begin
      bad++; $error("FAIL %s illegal_req got=%b want=%b", tag, illegal_req, m_ill);
    end
  endtask

  task automatic expect_const(input logic [31:0] want, input string tag);
    total++;
    assert (grant === want) else begin
      bad++; $error("FAIL %s const grant got=%h want=%h", tag, grant, want);
    end
  endtask

  initial begin
    logic [31:0] r;
    req = 32'h0; clear = 1'b1;
    m_holder = -1; m_ptr = 0; m_cnt = 0; m_ill = 1'b0; m_grant = 32'h0;

    // reset while every legal source requests
    step(32'h00FFFFFF, 1'b1, "reset0");
    expect_const(32'h0, "reset0");
    step(32'h00FFFFFF, 1'b1, "reset1");
    expect_const(32'h0, "reset1");
    step(32'h00FFFFFF, 1'b0, "first_grant");
    expect_const(32'h00000001, "first_grant");

    // single requester keeps the bus
    step(32'h0, 1'b1, "clr");
    for (int i = 0; i < 10; i++) begin
      step(32'h00000020, 1'b0, "single");
      expect_const(32'h00000020, "single");
    end
    step(32'h0, 1'b0, "single_drop");
    expect_const(32'h0, "single_drop");

    // two requesters alternate every MT cycles
    for (int i = 0; i < 16; i++) begin
      step(32'h00000005, 1'b0, "rr_preempt");
      expect_const(((i / MT) % 2 == 0) ? 32'h1 : 32'h4, "rr_preempt");
    end

    // release handoff without bubble
    step(32'h0, 1'b1, "clr");
    step(32'h00000002, 1'b0, "handoff_a");
    expect_const(32'h00000002, "handoff_a");
    step(32'h00000080, 1'b0, "handoff_b");
    expect_const(32'h00000080, "handoff_b");

    // wrap-around from ptr = 23
    step(32'h0, 1'b1, "clr");
    step(32'h00400000, 1'b0, "wrap_setup");
    step(32'h00800001, 1'b0, "wrap_23");
    expect_const(32'h00800000, "wrap_23");
    step(32'h00000001, 1'b0, "wrap_0");
    expect_const(32'h00000001, "wrap_0");

    // out-of-range requests
    step(32'h0, 1'b1, "clr");
    step(32'h81000000, 1'b0, "illegal");
    expect_const(32'h0, "illegal");
    step(32'h0, 1'b0, "illegal_off");

    // clear mid-tenure restarts the pointer at 0
    step(32'h00000004, 1'b0, "mid_a");
    step(32'h00000004, 1'b1, "mid_clear");
    expect_const(32'h0, "mid_clear");
    step(32'h00000009, 1'b0, "mid_restart");
    expect_const(32'h00000001, "mid_restart");

    // randomized traffic with persistent requests and rare clears
    r = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        r = ($urandom & $urandom & 32'h00FFFFFF) |
            (($urandom_range(0, 9) == 0) ? ($urandom & 32'hFF000000) : 32'h0);
      step(r, ($urandom_range(0, 59) == 0), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
